// File: rtl/tdes_sequencer.sv
// ---------------------------------------------------------------------------
// tdes_sequencer
//
// Purpose:
//   Drives an external single-DES core three times per request to build a
//   triple-DES operation. Encrypt runs the EDE chain (K1 enc, K2 dec, K3 enc)
//   and decrypt runs the DED chain (K3 dec, K2 enc, K1 dec). The block is
//   latched on start, fed to the core one pass at a time, and each pass
//   result becomes the input of the next pass. After the third pass the
//   result appears on dout with a one-cycle done pulse.
//
// Parameters:
//   DATA_W   block width of all data buses
//   TIMEOUT  cycles waited for des_done in one pass before giving up
//            (only meaningful when TDES_TIMEOUT_EN is defined)
//
// Configuration macro:
//   TDES_TIMEOUT_EN  when defined, a stalled pass that reaches TIMEOUT
//                    cycles without des_done moves the sequencer to ERR and
//                    raises err. When undefined, the sequencer waits for the
//                    core indefinitely and err is held at 0.
//
// Ports:
//   HCLK         clock, all state changes on the rising edge
//   HRESET       asynchronous active-low reset
//   start        request one triple-DES operation on din
//   decrypt      0 = encrypt (EDE), 1 = decrypt (DED), sampled with start
//   abort        cancel the current operation and return to IDLE
//   din          input block, sampled with start
//   des_start    one-cycle pulse launching one DES pass
//   des_decrypt  direction of the current pass
//   des_key_sel  key of the current pass (0 = K1, 1 = K2, 2 = K3)
//   des_din      block fed to the DES core
//   des_done     DES core pass complete, des_dout valid
//   des_dout     DES core result
//   dout         final result, held until the next completion or reset
//   busy         operation in progress (ISSUE, WAIT, DONE)
//   done         one-cycle completion pulse
//   err          timeout error flag
// ---------------------------------------------------------------------------
module tdes_sequencer #(
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              start,
   input  logic              decrypt,
   input  logic              abort,
   input  logic [DATA_W-1:0] din,
   output logic              des_start,
   output logic              des_decrypt,
   output logic [1:0]        des_key_sel,
   output logic [DATA_W-1:0] des_din,
   input  logic              des_done,
   input  logic [DATA_W-1:0] des_dout,
   output logic [DATA_W-1:0] dout,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Elaboration-time sanity checks on the parameters; these never produce
   // hardware.
   if (DATA_W < 1) begin : g_bad_data_w
      $error("tdes_sequencer: DATA_W must be at least 1");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("tdes_sequencer: TIMEOUT must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      ERR
   } state_t;

   state_t            state;
   logic [1:0]        pass;
   logic [1:0]        pass_next;
   logic              mode;
   logic [DATA_W-1:0] work;

`ifdef TDES_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] tmo_cnt;
`endif

   assign pass_next = pass + 2'd1;

   // Key used by a given pass. Encrypt walks K1, K2, K3; decrypt walks the
   // same keys in reverse order so it undoes the encrypt chain.
   function automatic logic [1:0] key_for(input logic [1:0] p, input logic dir);
      logic [1:0] k;
      k = 2'd0;
      case (p)
         2'd0:    k = dir ? 2'd2 : 2'd0;
         2'd1:    k = 2'd1;
         default: k = dir ? 2'd0 : 2'd2;
      endcase
      return k;
   endfunction

   // Direction of a given pass. The middle pass always runs opposite to
   // the outer two, which is what makes the chain EDE or DED.
   function automatic logic dir_for(input logic [1:0] p, input logic dir);
      return dir ^ p[0];
   endfunction

   // Single sequencer process. Every output is a register so the DES core
   // and the consumer of dout see glitch-free signals. Abort is checked
   // before anything else so it wins over start and over a des_done that
   // lands in the same cycle; that des_done is simply dropped. des_key_sel
   // and des_decrypt are loaded on the way into ISSUE and left alone in
   // WAIT, so they stay stable for the whole pass.
   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         state       <= IDLE;
         pass        <= 2'd0;
         mode        <= 1'b0;
         work        <= '0;
         des_start   <= 1'b0;
         des_decrypt <= 1'b0;
         des_key_sel <= 2'd0;
         des_din     <= '0;
         dout        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef TDES_TIMEOUT_EN
         err         <= 1'b0;
         tmo_cnt     <= '0;
`endif
      end else if (abort) begin
         state     <= IDLE;
         pass      <= 2'd0;
         des_start <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef TDES_TIMEOUT_EN
         err       <= 1'b0;
         tmo_cnt   <= '0;
`endif
      end else begin
         des_start <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE, ERR: begin
               if (start) begin
                  work        <= din;
                  des_din     <= din;
                  mode        <= decrypt;
                  pass        <= 2'd0;
                  des_key_sel <= key_for(2'd0, decrypt);
                  des_decrypt <= dir_for(2'd0, decrypt);
                  des_start   <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ISSUE;
`ifdef TDES_TIMEOUT_EN
                  err         <= 1'b0;
                  tmo_cnt     <= '0;
`endif
               end
            end

            ISSUE: begin
               state <= WAIT;
`ifdef TDES_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end

            WAIT: begin
               if (des_done) begin
                  work    <= des_dout;
                  des_din <= des_dout;
                  if (pass == 2'd2) begin
                     dout  <= des_dout;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     pass        <= pass_next;
                     des_key_sel <= key_for(pass_next, mode);
                     des_decrypt <= dir_for(pass_next, mode);
                     des_start   <= 1'b1;
                     state       <= ISSUE;
                  end
               end
`ifdef TDES_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  // Core never answered: drop the operation and flag it.
                  busy  <= 1'b0;
                  err   <= 1'b1;
                  state <= ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef TDES_TIMEOUT_EN
   // Without the timeout option there is no way to reach ERR.
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tdes_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tdes_sequencer
//
// Directed bench for tdes_sequencer. A small DES core stand-in answers each
// des_start two cycles later with a keyed rotate/xor of the block it was
// given. Cycle k below is the clock period that follows rising edge k-1,
// where edge 0 is the edge that samples start. Outputs are sampled on the
// falling edge, in the middle of each period.
// ---------------------------------------------------------------------------
module tb_tdes_sequencer;

   localparam logic [63:0] K1 = 64'h0F1E_2D3C_4B5A_6978;
   localparam logic [63:0] K2 = 64'h1122_3344_5566_7788;
   localparam logic [63:0] K3 = 64'hA5A5_A5A5_C3C3_C3C3;

   logic        HCLK;
   logic        HRESET;
   logic        start;
   logic        decrypt;
   logic        abort;
   logic [63:0] din;
   logic        des_start;
   logic        des_decrypt;
   logic [1:0]  des_key_sel;
   logic [63:0] des_din;
   logic        des_done;
   logic [63:0] des_dout;
   logic [63:0] dout;
   logic        busy;
   logic        done;
   logic        err;

   int          nVectors;
   int          nMiscompares;
   logic [63:0] prevDout;

   // Core stand-in controls.
   logic        stubEn;
   logic        forceDone;
   logic        stubP1;
   logic        stubDone;
   logic [63:0] stubDout;
   logic [63:0] capDin;
   logic [1:0]  capKey;
   logic        capDir;

   tdes_sequencer #(
      .DATA_W  (64),
      .TIMEOUT (4)
   ) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .start       (start),
      .decrypt     (decrypt),
      .abort       (abort),
      .din         (din),
      .des_start   (des_start),
      .des_decrypt (des_decrypt),
      .des_key_sel (des_key_sel),
      .des_din     (des_din),
      .des_done    (des_done),
      .des_dout    (des_dout),
      .dout        (dout),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   // Free-running clock, 10 time units per period.
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // What the core stand-in computes for one pass.
   function automatic logic [63:0] stubModel(input logic [63:0] x, input logic [1:0] k,
                                             input logic d);
      logic [63:0] kv;
      case (k)
         2'd0:    kv = K1;
         2'd1:    kv = K2;
         default: kv = K3;
      endcase
      return {x[55:0], x[63:56]} ^ kv ^ (d ? 64'hF0F0_F0F0_F0F0_F0F0 : 64'h0);
   endfunction

   // Core stand-in: captures the pass arguments when des_start is seen and
   // answers with des_done exactly two cycles after the des_start cycle.
   always @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         stubP1   <= 1'b0;
         stubDone <= 1'b0;
         stubDout <= 64'h0;
         capDin   <= 64'h0;
         capKey   <= 2'd0;
         capDir   <= 1'b0;
      end else begin
         stubP1 <= des_start & stubEn;
         if (des_start) begin
            capDin <= des_din;
            capKey <= des_key_sel;
            capDir <= des_decrypt;
         end
         stubDone <= stubP1;
         stubDout <= stubP1 ? stubModel(capDin, capKey, capDir) : 64'hDEAD_BEEF_DEAD_BEEF;
      end
   end

   assign des_done = stubDone | forceDone;
   assign des_dout = stubDout;

   // The one place a comparison is made and counted.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nVectors++;
      if (got !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Every output must read zero while reset is asserted.
   task automatic checkResetState(input string tag);
      checkOutput({tag, " des_start"},   64'(des_start),   64'h0);
      checkOutput({tag, " des_decrypt"}, 64'(des_decrypt), 64'h0);
      checkOutput({tag, " des_key_sel"}, 64'(des_key_sel), 64'h0);
      checkOutput({tag, " des_din"},     des_din,          64'h0);
      checkOutput({tag, " dout"},        dout,             64'h0);
      checkOutput({tag, " busy"},        64'(busy),        64'h0);
      checkOutput({tag, " done"},        64'(done),        64'h0);
      checkOutput({tag, " err"},         64'(err),         64'h0);
   endtask

   // Runs one operation and checks every output for 14 cycles.
   // mode 0: plain run; mode 1: start re-asserted with all-ones data in
   // cycle 5; mode 2: abort together with a stray des_done in cycle 5.
   task automatic applyStimulus(input string tag, input logic dec, input logic [63:0] data,
                                input int mode);
      logic [1:0]  keyTab [3];
      logic        dirTab [3];
      logic [63:0] stage  [4];
      int          last;
      int          p;
      logic        expStart;
      if (dec) begin
         keyTab = '{2'd2, 2'd1, 2'd0};
         dirTab = '{1'b1, 1'b0, 1'b1};
      end else begin
         keyTab = '{2'd0, 2'd1, 2'd2};
         dirTab = '{1'b0, 1'b1, 1'b0};
      end
      stage[0] = data;
      for (int i = 0; i < 3; i++) stage[i+1] = stubModel(stage[i], keyTab[i], dirTab[i]);
      last = (mode == 2) ? 5 : 10;

      @(negedge HCLK);
      start   = 1'b1;
      decrypt = dec;
      din     = data;
      for (int k = 1; k <= 14; k++) begin
         @(negedge HCLK);
         if (k == 1) start = 1'b0;
         if (mode == 1 && k == 5) begin start = 1'b1; din = 64'hFFFF_FFFF_FFFF_FFFF; end
         if (mode == 1 && k == 6) start = 1'b0;
         if (mode == 2 && k == 5) begin abort = 1'b1; forceDone = 1'b1; end
         if (mode == 2 && k == 6) begin abort = 1'b0; forceDone = 1'b0; end

         expStart = (k == 1) || (k == 4) || (k == 7 && mode != 2);
         checkOutput($sformatf("%s c%0d des_start", tag, k), 64'(des_start), 64'(expStart));
         checkOutput($sformatf("%s c%0d done", tag, k), 64'(done),
                     64'(mode != 2 && k == 10));
         checkOutput($sformatf("%s c%0d busy", tag, k), 64'(busy), 64'(k <= last));
         checkOutput($sformatf("%s c%0d err", tag, k), 64'(err), 64'h0);
         if (k <= 9 && k <= last) begin
            p = (k - 1) / 3;
            checkOutput($sformatf("%s c%0d key_sel", tag, k), 64'(des_key_sel), 64'(keyTab[p]));
            checkOutput($sformatf("%s c%0d des_decrypt", tag, k), 64'(des_decrypt),
                        64'(dirTab[p]));
            if (expStart)
               checkOutput($sformatf("%s c%0d des_din", tag, k), des_din, stage[p]);
         end
         checkOutput($sformatf("%s c%0d dout", tag, k), dout,
                     (mode != 2 && k >= 10) ? stage[3] : prevDout);
      end
      if (mode != 2) prevDout = stage[3];
   endtask

   // Reset asserted for one edge, checked, then released.
   task automatic pulseReset(input string tag);
      @(negedge HCLK);
      HRESET = 1'b0;
      #1;
      checkResetState(tag);
      @(negedge HCLK);
      HRESET   = 1'b1;
      prevDout = 64'h0;
   endtask

   initial begin
      nVectors     = 0;
      nMiscompares = 0;
      prevDout     = 64'h0;
      HRESET       = 1'b0;
      start        = 1'b0;
      decrypt      = 1'b0;
      abort        = 1'b0;
      din          = 64'h0;
      stubEn       = 1'b1;
      forceDone    = 1'b0;

      repeat (2) @(negedge HCLK);
      checkResetState("reset");
      HRESET = 1'b1;
      @(negedge HCLK);
      checkOutput("idle busy", 64'(busy), 64'h0);

      $display("[TB] encrypt / decrypt / ignored restart");
      applyStimulus("enc", 1'b0, 64'h0123_4567_89AB_CDEF, 0);
      applyStimulus("dec", 1'b1, 64'h0123_4567_89AB_CDEF, 0);
      applyStimulus("restart", 1'b0, 64'h0123_4567_89AB_CDEF, 1);

      $display("[TB] abort with coincident des_done");
      pulseReset("reset2");
      applyStimulus("abort", 1'b0, 64'h0123_4567_89AB_CDEF, 2);

      $display("[TB] core never answers");
      stubEn = 1'b0;
      @(negedge HCLK);
      start   = 1'b1;
      decrypt = 1'b0;
      din     = 64'h5555_AAAA_1234_5678;
      for (int k = 1; k <= 12; k++) begin
         @(negedge HCLK);
         if (k == 1) start = 1'b0;
         checkOutput($sformatf("stall c%0d des_start", k), 64'(des_start), 64'(k == 1));
         checkOutput($sformatf("stall c%0d done", k), 64'(done), 64'h0);
`ifdef TDES_TIMEOUT_EN
         checkOutput($sformatf("stall c%0d err", k), 64'(err), 64'(k >= 6));
         checkOutput($sformatf("stall c%0d busy", k), 64'(busy), 64'(k <= 5));
`else
         checkOutput($sformatf("stall c%0d err", k), 64'(err), 64'h0);
         checkOutput($sformatf("stall c%0d busy", k), 64'(busy), 64'h1);
`endif
      end
`ifndef TDES_TIMEOUT_EN
      @(negedge HCLK);
      abort = 1'b1;
      @(negedge HCLK);
      abort = 1'b0;
      checkOutput("stall abort busy", 64'(busy), 64'h0);
`endif
      stubEn = 1'b1;
      applyStimulus("recover", 1'b1, 64'hFEDC_BA98_7654_3210, 0);

      $display("[TB] reset in last pass");
      @(negedge HCLK);
      start   = 1'b1;
      decrypt = 1'b0;
      din     = 64'h0F0F_0000_FFFF_1234;
      for (int k = 1; k <= 8; k++) begin
         @(negedge HCLK);
         if (k == 1) start = 1'b0;
      end
      checkOutput("midop busy", 64'(busy), 64'h1);
      checkOutput("midop key_sel", 64'(des_key_sel), 64'h2);
      HRESET = 1'b0;
      #1;
      checkResetState("midop reset");
      @(negedge HCLK);
      HRESET = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge HCLK);
         checkOutput($sformatf("post c%0d done", k), 64'(done), 64'h0);
         checkOutput($sformatf("post c%0d busy", k), 64'(busy), 64'h0);
         checkOutput($sformatf("post c%0d des_start", k), 64'(des_start), 64'h0);
         checkOutput($sformatf("post c%0d dout", k), dout, 64'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
